// File: rtl/jtframe_cpuwait.sv
// CPU clock-enable gating for SDRAM ROM waits and shared-memory arbitration.
// Cycles lost to a stall are counted and replayed on idle cycles when recovery is on.
module jtframe_cpuwait #(
  parameter int unsigned ROMCNT   = 1,
  parameter int unsigned DEVCNT   = 2,
  parameter int unsigned RECOVERY = 1,
  parameter int unsigned DW       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_in,
  output logic              cen_out,
  output logic              gate,
  input  logic [DEVCNT-1:0] dev_busy,
  input  logic [ROMCNT-1:0] rom_cs,
  input  logic [ROMCNT-1:0] rom_ok,
  output logic [DW-1:0]     debt
);

  localparam bit            REC_EN   = (RECOVERY != 0);
  localparam logic [DW-1:0] DEBT_MAX = '1;

  logic [ROMCNT-1:0] last_rom_cs_q, last_rom_cs_d;
  logic [ROMCNT-1:0] waitn_q, waitn_d;
  logic [DW-1:0]     debt_q, debt_d;
  logic              gate_q, gate_d;
  logic              cen_out_q, cen_out_d;
  logic [ROMCNT-1:0] cs_rise;
  logic              stall;
  logic              rec;

  // Wait tracking, stall detection and lost-cycle bookkeeping
  always_comb begin
    cs_rise       = rom_cs & ~last_rom_cs_q;
    last_rom_cs_d = rom_cs;
    waitn_d       = waitn_q;
    for (int i = 0; i < int'(ROMCNT); i++) begin
      // A new access always opens a wait, even if data is flagged ready the same cycle
      if (cs_rise[i]) begin
        waitn_d[i] = 1'b0;
      end else if (rom_ok[i] || !rom_cs[i]) begin
        waitn_d[i] = 1'b1;
      end
    end

    stall = ~(&waitn_q) | (|dev_busy);
    rec   = 1'b0;
    if (REC_EN) begin
      rec = ~stall & ~cen_in & (debt_q != '0) & ~cen_out_q;
    end

    debt_d = debt_q;
    if (REC_EN && cen_in && stall) begin
      if (debt_q != DEBT_MAX) begin
        debt_d = debt_q + DW'(1);
      end
    end else if (rec) begin
      debt_d = debt_q - DW'(1);
    end

    cen_out_d = (cen_in & ~stall) | rec;
    gate_d    = ~stall;
  end

  // Falling-edge registers so the CPU samples settled enables on the rising edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rom_cs_q <= '0;
      waitn_q       <= '1;
      debt_q        <= '0;
      gate_q        <= 1'b1;
      cen_out_q     <= 1'b0;
    end else begin
      last_rom_cs_q <= last_rom_cs_d;
      waitn_q       <= waitn_d;
      debt_q        <= debt_d;
      gate_q        <= gate_d;
      cen_out_q     <= cen_out_d;
    end
  end

  assign cen_out = cen_out_q;
  assign gate    = gate_q;
  assign debt    = debt_q;

endmodule

// File: tb/tb_jtframe_cpuwait.sv
// Scoreboard bench for jtframe_cpuwait: three instances (recovery DW=4, DW=2, no recovery)
// share one stimulus; expectations are queued by cycle and checked by a separate monitor.
module tb_jtframe_cpuwait;

  localparam int IA = 0, IB = 1, IC = 2;
  localparam int F_CEN = 0, F_GATE = 1, F_DEBT = 2, F_PCNT = 3, F_MARK = 4;

  typedef struct {
    int    cyc;
    int    inst;
    int    fld;
    int    val;
    string name;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen_in;
  logic [1:0] rom_cs, rom_ok, dev_busy;
  logic       cen_a, cen_b, cen_c, gate_a, gate_b, gate_c;
  logic [3:0] debt_a, debt_c;
  logic [1:0] debt_b;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pcnt [3];
  chk_t q [$];

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  jtframe_cpuwait #(.ROMCNT(2), .DEVCNT(2), .RECOVERY(1), .DW(4)) u_a (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cen_out(cen_a), .gate(gate_a),
    .dev_busy(dev_busy), .rom_cs(rom_cs), .rom_ok(rom_ok), .debt(debt_a));
  jtframe_cpuwait #(.ROMCNT(2), .DEVCNT(2), .RECOVERY(1), .DW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cen_out(cen_b), .gate(gate_b),
    .dev_busy(dev_busy), .rom_cs(rom_cs), .rom_ok(rom_ok), .debt(debt_b));
  jtframe_cpuwait #(.ROMCNT(2), .DEVCNT(2), .RECOVERY(0), .DW(4)) u_c (
    .clk(clk), .rst_n(rst_n), .cen_in(cen_in), .cen_out(cen_c), .gate(gate_c),
    .dev_busy(dev_busy), .rom_cs(rom_cs), .rom_ok(rom_ok), .debt(debt_c));

  function automatic int actual(input int inst, input int fld);
    case (fld)
      F_CEN:  return (inst == IA) ? int'(cen_a)  : (inst == IB) ? int'(cen_b)  : int'(cen_c);
      F_GATE: return (inst == IA) ? int'(gate_a) : (inst == IB) ? int'(gate_b) : int'(gate_c);
      F_DEBT: return (inst == IA) ? int'(debt_a) : (inst == IB) ? int'(debt_b) : int'(debt_c);
      default: return pcnt[inst];
    endcase
  endfunction

  task automatic process(input chk_t e);
    int got;
    if (e.fld == F_MARK) begin
      pcnt[e.inst] = 0;
    end else begin
      got = actual(e.inst, e.fld);
      checks++;
      if (got != e.val) begin
        failures++;
        $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", e.name, e.inst, cyc, got, e.val);
      end
    end
  endtask

  // Monitor: outputs are stable at the rising edge (the DUT updates on the falling edge)
  initial begin
    chk_t e;
    pcnt = '{0, 0, 0};
    forever begin
      @(posedge clk);
      pcnt[IA] += int'(cen_a);
      pcnt[IB] += int'(cen_b);
      pcnt[IC] += int'(cen_c);
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        process(e);
      end
      if (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL stale_%s inst=%0d cyc=%0d got=unchecked want=%0d", e.name, e.inst, cyc, e.val);
      end
    end
  end

  // Reset-assertion monitor: looks at outputs between clock edges
  initial begin
    chk_t e;
    forever begin
      @(negedge rst_n);
      #1;
      while (q.size() > 0 && q[0].cyc == -1) begin
        e = q.pop_front();
        process(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input int inst, input int fld, input int val, input string name);
    chk_t e;
    e.cyc = c; e.inst = inst; e.fld = fld; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic want(input int inst, input int fld, input int val, input string name);
    push(cyc + 1, inst, fld, val, name);
  endtask

  task automatic want_rst(input int inst, input int fld, input int val, input string name);
    push(-1, inst, fld, val, name);
  endtask

  task automatic drive(input logic cen, input logic [1:0] cs, input logic [1:0] ok,
                       input logic [1:0] busy);
    cen_in = cen; rom_cs = cs; rom_ok = ok; dev_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'b00, 2'b00, 2'b00);
      tick();
    end
  endtask

  task automatic mark();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) want(i, F_MARK, 0, "mark");
    tick();
  endtask

  task automatic want_pcnt(input int na, input int nb, input int nc, input string name);
    want(IA, F_PCNT, na, name);
    want(IB, F_PCNT, nb, name);
    want(IC, F_PCNT, nc, name);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    tick();
    want(IA, F_GATE, 1, "rst_gate");
    want(IA, F_CEN, 0, "rst_cen");
    want(IA, F_DEBT, 0, "rst_debt");
    want(IC, F_GATE, 1, "rst_gate_c");
    tick();
    rst_n = 1'b1;
    idle(3);
    want(IA, F_GATE, 1, "idle_gate");
    want(IB, F_DEBT, 0, "idle_debt");
    idle(1);

    // Single-channel wait with cen_in every 4th clock
    mark();
    for (int t = -4; t <= 23; t++) begin
      drive(((t + 8) % 4) == 2, {1'b0, t >= 0}, {1'b0, t >= 9}, 2'b00);
      case (t + 1)
        1:  want(IA, F_GATE, 1, "sw_gate_pre");
        2:  begin want(IA, F_GATE, 0, "sw_gate_low"); want(IC, F_GATE, 0, "sw_gate_low_c"); end
        3:  begin want(IA, F_CEN, 0, "sw_supp"); want(IC, F_CEN, 0, "sw_supp_c"); end
        7:  begin want(IA, F_DEBT, 2, "sw_debt2"); want(IB, F_DEBT, 2, "sw_debt2_b");
                  want(IC, F_DEBT, 0, "sw_debt0_c"); end
        10: want(IA, F_GATE, 0, "sw_gate_last");
        11: begin want(IA, F_GATE, 1, "sw_gate_up"); want(IA, F_CEN, 1, "sw_cen_resume"); end
        12: want(IA, F_DEBT, 2, "sw_debt_hold");
        13: begin want(IA, F_CEN, 1, "sw_rec1"); want(IA, F_DEBT, 1, "sw_debt1");
                  want(IC, F_CEN, 0, "sw_norec_c"); end
        17: begin want(IA, F_CEN, 1, "sw_rec2"); want(IA, F_DEBT, 0, "sw_debt_drained");
                  want(IB, F_DEBT, 0, "sw_debt_drained_b"); want(IC, F_CEN, 0, "sw_norec2_c"); end
        default: ;
      endcase
      tick();
    end
    idle(4);
    want_pcnt(7, 7, 5, "sw_pulses");
    idle(1);

    // Two channels rise together; only the later ok releases the stall
    mark();
    for (int t = 0; t <= 14; t++) begin
      drive(1'b0, (t <= 10) ? 2'b11 : 2'b00,
            (t <= 10) ? {t >= 7, t >= 3} : 2'b00, 2'b00);
      case (t + 1)
        1: want(IA, F_GATE, 1, "mc_gate_pre");
        2: want(IA, F_GATE, 0, "mc_gate_low");
        5: want(IA, F_GATE, 0, "mc_ok0_only");
        8: begin want(IA, F_GATE, 0, "mc_gate_wait1"); want(IC, F_GATE, 0, "mc_gate_wait1_c"); end
        9: begin want(IA, F_GATE, 1, "mc_gate_up"); want(IC, F_GATE, 1, "mc_gate_up_c");
                 want(IA, F_DEBT, 0, "mc_debt_idle"); end
        default: ;
      endcase
      tick();
    end
    want_pcnt(0, 0, 0, "mc_pulses");
    idle(1);

    // cs rise and ok in the same cycle: the wait still opens
    mark();
    for (int t = 0; t <= 4; t++) begin
      drive(1'b0, (t <= 2) ? 2'b01 : 2'b00, (t <= 2) ? 2'b01 : 2'b00, 2'b00);
      case (t + 1)
        2: want(IA, F_GATE, 0, "pri_clear_wins");
        3: want(IA, F_GATE, 1, "pri_gate_up");
        default: ;
      endcase
      tick();
    end
    idle(1);

    // Saturation: 6 stalled cen_in pulses
    mark();
    for (int t = 0; t <= 27; t++) begin
      drive((t <= 11) && (t % 2 == 1), 2'b00, 2'b00, (t <= 11) ? 2'b01 : 2'b00);
      case (t + 1)
        2:  want(IB, F_DEBT, 1, "sat_debt1_b");
        6:  want(IB, F_DEBT, 3, "sat_max_b");
        8:  want(IB, F_DEBT, 3, "sat_nowrap_b");
        12: begin want(IB, F_DEBT, 3, "sat_end_b"); want(IA, F_DEBT, 6, "sat_debt6");
                  want(IA, F_GATE, 0, "sat_gate_low"); want(IC, F_DEBT, 0, "sat_debt_c"); end
        13: begin want(IA, F_GATE, 1, "sat_gate_up"); want(IB, F_CEN, 1, "sat_rec1_b"); end
        14: want(IB, F_CEN, 0, "sat_gap_b");
        17: want(IB, F_DEBT, 0, "sat_drained_b");
        19: want(IB, F_CEN, 0, "sat_nomore_b");
        22: want(IA, F_DEBT, 1, "sat_debt_last");
        23: want(IA, F_DEBT, 0, "sat_drained");
        default: ;
      endcase
      tick();
    end
    want_pcnt(6, 3, 0, "sat_pulses");
    idle(1);

    // dev_busy[1] for 5 clocks with cen_in held high
    mark();
    for (int t = 0; t <= 19; t++) begin
      drive(t <= 4, 2'b00, 2'b00, (t <= 4) ? 2'b10 : 2'b00);
      case (t + 1)
        3:  want(IA, F_CEN, 0, "busy_cen_off");
        5:  begin want(IA, F_CEN, 0, "busy_cen_off_end"); want(IA, F_DEBT, 5, "busy_debt5");
                  want(IB, F_DEBT, 3, "busy_debt_b"); want(IC, F_DEBT, 0, "busy_debt_c"); end
        6:  begin want(IA, F_CEN, 1, "busy_rec1"); want(IC, F_CEN, 0, "busy_norec_c"); end
        7:  want(IA, F_CEN, 0, "busy_rec_gap");
        8:  want(IA, F_CEN, 1, "busy_rec2");
        10: want(IB, F_DEBT, 0, "busy_drained_b");
        13: want(IA, F_DEBT, 1, "busy_debt_last");
        14: want(IA, F_DEBT, 0, "busy_drained");
        default: ;
      endcase
      tick();
    end
    want_pcnt(5, 3, 0, "busy_pulses");
    idle(1);

    // Reset in the middle of recovery, with rom_cs held high across it
    mark();
    for (int t = 0; t <= 6; t++) begin
      drive((t <= 5) && (t % 2 == 1), 2'b00, 2'b00, (t <= 5) ? 2'b01 : 2'b00);
      case (t + 1)
        6: begin want(IA, F_DEBT, 3, "mr_debt3"); want(IA, F_GATE, 0, "mr_gate_low"); end
        7: begin want(IA, F_DEBT, 2, "mr_debt2"); want(IA, F_CEN, 1, "mr_rec");
                 want(IB, F_CEN, 1, "mr_rec_b"); end
        default: ;
      endcase
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      want_rst(i, F_CEN, 0, "mr_rst_cen");
      want_rst(i, F_GATE, 1, "mr_rst_gate");
      want_rst(i, F_DEBT, 0, "mr_rst_debt");
    end
    drive(1'b0, 2'b01, 2'b00, 2'b00);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) want(i, F_MARK, 0, "mark");
    tick();
    rst_n = 1'b1;
    tick();
    for (int t = 9; t <= 20; t++) begin
      drive(1'b0, (t <= 14) ? 2'b01 : 2'b00, (t >= 11 && t <= 14) ? 2'b01 : 2'b00, 2'b00);
      case (t + 1)
        10: begin want(IA, F_GATE, 0, "mr_cs_rise"); want(IC, F_GATE, 0, "mr_cs_rise_c"); end
        12: want(IA, F_GATE, 0, "mr_wait_hold");
        13: want(IA, F_GATE, 1, "mr_gate_up");
        21: want(IA, F_DEBT, 0, "mr_debt_after");
        default: ;
      endcase
      tick();
    end
    want_pcnt(0, 0, 0, "mr_no_pulses");
    idle(3);

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_left got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_cpuwait.md
JTFRAME_CPUWAIT -- requirements
Module: jtframe_cpuwait

Interface
REQ-001 SHALL have parameter ROMCNT, default 1, meaning number of independent SDRAM ROM channels (>=1).
REQ-002 SHALL have parameter DEVCNT, default 2, meaning number of shared-memory busy inputs (>=1).
REQ-003 SHALL have parameter RECOVERY, default 1, meaning 1 enables lost-cycle recovery and 0 disables it.
REQ-004 SHALL have parameter DW, default 4, meaning width of the lost-cycle debt counter.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port cen_in, input, 1 bit: raw CPU clock-enable pulse train.
REQ-008 SHALL have port cen_out, output, 1 bit: gated and recovered CPU clock enable.
REQ-009 SHALL have port gate, output, 1 bit: 1 when the CPU is not stalled.
REQ-010 SHALL have port dev_busy, input, DEVCNT bits: shared-memory arbitration busy flags.
REQ-011 SHALL have port rom_cs, input, ROMCNT bits: per-channel ROM chip select.
REQ-012 SHALL have port rom_ok, input, ROMCNT bits: per-channel ROM data valid.
REQ-013 SHALL have port debt, output, DW bits: current outstanding lost-cycle count.

Function
REQ-014 SHALL update all registers on the falling edge of clk, so the CPU sees stable cen_out and gate at the rising edge.
REQ-015 SHALL register last_rom_cs[i] each cycle and define cs_rise[i] = rom_cs[i] & ~last_rom_cs[i].
REQ-016 SHALL clear per-channel waitn[i] on cs_rise[i], else set it when rom_ok[i] or ~rom_cs[i]; on a simultaneous cs_rise and rom_ok, the clear SHALL win.
REQ-017 SHALL define stall = ~(&waitn) | (|dev_busy), evaluated from the current register and input values.
REQ-018 SHALL register gate <= ~stall.
REQ-019 SHALL increment debt, saturating at 2^DW-1, on each cycle with cen_in=1 and stall=1.
REQ-020 SHALL, when RECOVERY=1, assert a recovered pulse (rec=1) on a cycle with stall=0, cen_in=0, debt!=0 and cen_out currently 0; that cycle SHALL decrement debt by 1.
REQ-021 SHALL register cen_out <= (cen_in & ~stall) | rec, so cen_out is never high on two consecutive cycles due to recovery.
REQ-022 SHALL hold debt at 0 and rec at 0 permanently when RECOVERY=0, which makes cen_out equal to cen_in & ~stall delayed one cycle.
REQ-023 SHALL treat increment and decrement as mutually exclusive by construction (cen_in distinguishes them); debt SHALL never wrap below 0 or above its maximum.
REQ-024 SHALL let channels stall independently: the CPU SHALL resume only when every asserted channel has rom_ok and all dev_busy bits are 0.
REQ-025 SHALL hold debt unchanged during a stall when cen_in=0, and during a free run with debt=0.

Reset
REQ-026 SHALL, on rst_n low and regardless of clk, force cen_out=0, gate=1, debt=0, waitn all 1, and last_rom_cs all 0.
REQ-027 SHALL, on a reset asserted mid-stall or mid-recovery, discard the pending wait and the accumulated debt; after release, a rom_cs already high SHALL count as a rising edge.

Verification
REQ-028 SHALL verify a single-channel wait: cen_in every 4th clk, rom_cs[0] rises, rom_ok rises 9 clks later -> gate low during the wait, 2 cen_in pulses suppressed, debt=2, then 2 extra cen_out pulses on idle cycles, debt back to 0.
REQ-029 SHALL verify multi-channel operation: ROMCNT=2, both cs rise together, ok[0] at +3 and ok[1] at +7 -> gate stays low until ok[1], then returns to 1 one negedge later.
REQ-030 SHALL verify saturation: DW=2, stall held through 6 cen_in pulses -> debt reads 3 and never wraps; exactly 3 recovered pulses follow.
REQ-031 SHALL verify RECOVERY=0: same stimulus as REQ-028 -> debt stays 0, no extra pulses, cen_out = delayed cen_in & gate.
REQ-032 SHALL verify dev_busy: dev_busy[1]=1 for 5 clks with cen_in held at 1 -> cen_out=0 and debt=5 (DW=4); after release the debt drains at one pulse per two clks at most.
REQ-033 SHALL verify reset mid-recovery: debt=3, then rst_n pulsed low -> immediately cen_out=0, gate=1, debt=0, and no recovered pulses after release.
